// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the fetch PC, talks to a variable-latency
// instruction memory (one request outstanding at most) and drives the IF/ID register.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [2:0] {BOOT, REQ, WAIT, KILL, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;

    logic        slot_free;
    logic        load;
    logic [31:0] load_instr;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign slot_free = !valid_q || !StallD;
    assign target    = PCTargetE & 32'hFFFF_FFFC;
    assign pc_inc    = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        load         = 1'b0;
        load_instr   = imem_rdata;
        case (state_q)
            BOOT: begin
                state_d = REQ;
                if (PCSrcE) pc_d = target;
            end
            REQ: begin
                if (imem_ready) begin
                    state_d = PCSrcE ? KILL : WAIT;
                end
                if (PCSrcE) pc_d = target;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (PCSrcE) begin
                        pc_d    = target;
                        state_d = REQ;
                    end else if (slot_free) begin
                        load    = 1'b1;
                        state_d = REQ;
                    end else begin
                        hold_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end
                end else if (PCSrcE) begin
                    pc_d    = target;
                    state_d = KILL;
                end
            end
            KILL: begin
                // The stale response closes the old transaction; a redirect only retargets pc.
                if (imem_rvalid) state_d = REQ;
                if (PCSrcE) pc_d = target;
            end
            HOLD: begin
                load_instr = hold_instr_q;
                if (PCSrcE) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (slot_free) begin
                    load    = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase

        if (load) pc_d = pc_inc;
    end

    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (load) begin
            instr_d = load_instr;
            pcd_d   = pc_q;
            pcp4_d  = pc_inc;
        end
        // Flush wins over load and stall; data fields may stay stale.
        if (PCSrcE)                 valid_d = 1'b0;
        else if (load)              valid_d = 1'b1;
        else if (valid_q && !StallD) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            hold_instr_q <= 32'h0;
            instr_q      <= 32'h0;
            pcd_q        <= 32'h0;
            pcp4_q       <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            pcp4_q       <= pcp4_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pcp4_q;
    assign ValidD    = valid_q;

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch for the 5-stage RISC-V pipeline against an instruction memory with variable latency, using a request/accept and response-valid handshake. It owns the fetch PC, applies branch/jump redirects from Execute, absorbs Decode stalls with a one-entry hold buffer, and drives the IF/ID pipeline register (InstrD, PCD, PCPlus4D, ValidD). It replaces the free-running PC and zero-latency memory path in the fetch stage. At most one fetch is outstanding at any time.

## Interface
- RESET_PC, 32'h00000000, fetch address loaded at reset.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- PCSrcE  in  1  redirect request from Execute (branch taken / jump).
- PCTargetE  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- StallD  in  1  Decode cannot accept; IF/ID holds when ValidD=1.
- imem_req  out  1  fetch request, high only in REQ.
- imem_addr  out  32  byte address of the fetch (the current pc); bits [1:0] are always 0.
- imem_ready  in  1  memory accepts the request when imem_req && imem_ready.
- imem_rvalid  in  1  response valid, one cycle per accepted request, latency ≥1 cycle.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- InstrD, PCD, PCPlus4D  out  32 each  IF/ID register contents.
- ValidD  out  1  IF/ID holds a live instruction.

## Operation
- State registers: state ∈ {BOOT, REQ, WAIT, KILL, HOLD}, pc[31:0], hold buffer (hold_instr[31:0]).
- slot_free = !ValidD || !StallD.
- pc+4 is modulo 2^32, so 32'hFFFFFFFC+4 = 32'h00000000. PCPlus4D = PCD+4, computed the same way.
- BOOT: no request, imem_rvalid ignored. Next state is REQ. If PCSrcE=1, pc<=PCTargetE.
- REQ: imem_req=1, imem_addr=pc.
  - Accepted and PCSrcE=1: pc<=target, go to KILL.
  - Accepted and PCSrcE=0: go to WAIT.
  - Not accepted and PCSrcE=1: pc<=target, stay in REQ. The address may change before acceptance.
- WAIT, imem_rvalid=1:
  - PCSrcE=1: discard the response, pc<=target, go to REQ.
  - slot_free: load IF/ID with {imem_rdata, pc, pc+4}, ValidD<=1, pc<=pc+4, go to REQ.
  - Otherwise: hold_instr<=imem_rdata, go to HOLD.
- WAIT, imem_rvalid=0 and PCSrcE=1: pc<=target, go to KILL.
- KILL: waits for the stale response. On imem_rvalid, drop the data and go to REQ. PCSrcE updates pc again and the state stays KILL.
- HOLD: no request.
  - PCSrcE=1: drop the buffer, pc<=target, go to REQ.
  - slot_free: load IF/ID with {hold_instr, pc, pc+4}, ValidD<=1, pc<=pc+4, go to REQ.
- ValidD update priority:
  1. PCSrcE=1 forces ValidD<=0. Flush overrides StallD. InstrD/PCD/PCPlus4D may keep stale values.
  2. Otherwise, a load sets ValidD<=1.
  3. Otherwise, if ValidD && !StallD, ValidD<=0 (instruction consumed).
  4. Otherwise, hold.
- imem_rvalid in REQ, BOOT, or HOLD is a protocol violation and is ignored.

## Timing
- Reset (asynchronous, immediate):
  - state=BOOT, pc=RESET_PC, hold_instr=0.
  - imem_req=0, imem_addr=RESET_PC.
  - InstrD=PCD=PCPlus4D=0, ValidD=0.
- After reset release:
  - Edge 1: BOOT→REQ.
  - Cycle 2: imem_req=1.
- With imem_ready=1 and 1-cycle rvalid latency, throughput is one instruction per 2 cycles (REQ, WAIT).
- The IF/ID register is valid on the edge after the imem_rvalid cycle.
- Redirect: the first request to the target is issued the cycle after PCSrcE, except in KILL, which first waits for the stale response. No instruction from before the redirect ever reaches ValidD=1 after the PCSrcE cycle.
- Reset mid-transaction: a response arriving after reset release lands in BOOT (ignored). If it arrives in a later state, its handling is the memory's responsibility; the memory must be reset together with this block.

## Test plan
- Reset and straight line:
  - Stimulus: RESET_PC=0, memory holds 0:FFC4A303, 4:00832383, 8:00736233, 12:FE44AE23; imem_ready=1, 1-cycle latency.
  - Required: imem_addr 0,4,8,12; InstrD in order with PCD=0,4,8,12 and PCPlus4D=4,8,12,16.
- Decode stall:
  - Stimulus: StallD=1 for 3 cycles while the fetch of addr 4 returns.
  - Required: state HOLD, no imem_req, InstrD stays FFC4A303. Cycle after StallD=0: InstrD=00832383, PCD=4. Next request addr 8.
- Redirect in WAIT:
  - Stimulus: PCSrcE=1, PCTargetE=0x40 while fetch 8 is outstanding with 3-cycle latency.
  - Required: ValidD=0 next cycle, late response dropped (KILL), next imem_addr=0x40, PCD=0x40.
- Simultaneous events:
  - Stimulus: PCSrcE=1, target 0x23, in the same cycle as imem_rvalid. Separately, in the same cycle as request acceptance.
  - Required: response discarded in both cases; imem_addr=0x20; the accepted case goes through KILL.
- Wrap:
  - Stimulus: RESET_PC=FFFFFFFC.
  - Required: PCD=FFFFFFFC, PCPlus4D=0, next imem_addr=0.
- Async reset mid-WAIT:
  - Stimulus: rst low between clock edges.
  - Required: all outputs at reset values immediately; first imem_req 2 cycles after release, addr=RESET_PC.
